sw_debounce: RTL and testbench

Switch-conditioning stage between the board slide switches and the 8-to-3 priority encoder / seven-segment path. It synchronises each raw switch to `clk` and filters out bounce. Each output bit updates only after its synchronised input has held a new value for `STABLE_CYCLES` consecutive cycles. Outputs feed the encoder directly: `sw_out[7:0]` drives the 8-bit code input and `sw_out[8]` drives the enable input. Per-bit edge pulses are also provided for event-driven consumers such as counters and LED latches.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/sw_debounce_bit.sv | 63 ++++++
 rtl/sw_debounce.sv | 52 +++++
 tb/tb_sw_debounce.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants for the slide-switch conditioning path.
//   STABLE_CYCLES_SIM   : short filter length used in simulation
//   STABLE_CYCLES_BOARD : 20 ms at 50 MHz for real switches
//   SW_WIDTH            : SW8..SW0
//   SW_ENABLE_BIT       : switch bit that drives the encoder enable
//   SW_CODE_MSB         : top bit of the 8-bit encoder code input
package debounce_pkg;

  localparam int STABLE_CYCLES_SIM   = 16;
  localparam int STABLE_CYCLES_BOARD = 1_000_000;
  localparam int SW_WIDTH            = 9;
  localparam int SW_ENABLE_BIT       = 8;
  localparam int SW_CODE_MSB         = 7;

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-bit switch conditioner: 2-flop synchroniser, mismatch counter,
// debounced output flop and registered rise/fall pulses.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   raw       asynchronous switch level
//   level     debounced level
//   rise      one-cycle pulse when level goes 0->1
//   fall      one-cycle pulse when level goes 1->0
//   flip_next high in the cycle before level flips (lets the parent
//             register an aggregate pulse aligned with rise/fall)
module sw_debounce_bit
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_SIM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic flip_next
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // The count only advances while s2 disagrees with level, so reaching
  // CNT_MAX on a mismatching cycle means STABLE_CYCLES mismatches in a row.
  always_comb begin
    flip_next = (s2 != level) && (cnt == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= flip_next & s2;
      fall <= flip_next & ~s2;
      if (s2 == level) begin
        cnt <= '0;
      end else if (flip_next) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Debounces the board slide switches feeding the priority encoder.
// sw_out[7:0] is the encoder code, sw_out[8] the encoder enable.
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   sw_in    raw asynchronous switch levels
//   sw_out   debounced, registered switch levels
//   rise     per-bit one-cycle pulse on 0->1 of sw_out
//   fall     per-bit one-cycle pulse on 1->0 of sw_out
//   changed  registered OR of all rise/fall pulses
module sw_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = STABLE_CYCLES_SIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] flip_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (sw_in[i]),
      .level    (sw_out[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .flip_next(flip_next[i])
    );
  end

  // Registered from the per-bit pre-flip strobes so it lands in the same
  // cycle as rise/fall; several bits flipping together give one pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      changed <= 1'b0;
    end else begin
      changed <= |flip_next;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;
  import debounce_pkg::*;

  localparam int W  = SW_WIDTH;
  localparam int SC = 4;
  localparam int HMAX = 8192;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw_in;
  logic [W-1:0] sw_out;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         changed;

  sw_debounce #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .sw_out (sw_out),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: keeps the full history of sampled inputs and decides
  // each flip from a window over that history.
  int           t = 0;
  logic [W-1:0] hist [0:HMAX-1];
  int           last_rst = 0;
  int           last_flip [W];
  logic [W-1:0] m_out  = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;
  logic         m_chg  = 1'b0;

  // Synchronised value seen at edge e: the input sampled two edges earlier,
  // or 0 if that sample predates the last reset.
  function automatic logic s2_at(input int e, input int b);
    if (e - 2 > last_rst) return hist[e-2][b];
    return 1'b0;
  endfunction

  task automatic model_edge(input logic [W-1:0] v, input logic r);
    bit ok;
    int e;
    t++;
    hist[t] = v;
    m_rise = '0;
    m_fall = '0;
    m_chg  = 1'b0;
    if (!r) begin
      last_rst = t;
      m_out    = '0;
      return;
    end
    for (int b = 0; b < W; b++) begin
      ok = 1'b1;
      for (int j = 0; j < SC; j++) begin
        e = t - j;
        if (e <= last_rst || e <= last_flip[b]) ok = 1'b0;
        else if (s2_at(e, b) == m_out[b]) ok = 1'b0;
      end
      if (ok) begin
        m_out[b]     = ~m_out[b];
        last_flip[b] = t;
        if (m_out[b]) m_rise[b] = 1'b1;
        else          m_fall[b] = 1'b1;
      end
    end
    m_chg = |(m_rise | m_fall);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, t);
    end
  endtask

  task automatic cyc(input logic [W-1:0] v, input logic r);
    sw_in = v;
    rst_n = r;
    @(posedge clk);
    model_edge(v, r);
    #1;
    chk("sw_out",  32'(sw_out),  32'(m_out));
    chk("rise",    32'(rise),    32'(m_rise));
    chk("fall",    32'(fall),    32'(m_fall));
    chk("changed", 32'(changed), 32'(m_chg));
  endtask

  initial begin
    logic [W-1:0] v;
    logic         f5;
    for (int b = 0; b < W; b++) last_flip[b] = 0;
    sw_in = '0;
    rst_n = 1'b0;

    // Reset with all switches high
    repeat (3) cyc(9'h1FF, 1'b0);
    chk("rst_out", 32'(sw_out), 32'h0);
    chk("rst_chg", 32'(changed), 32'h0);
    repeat (8) cyc(9'h000, 1'b1);

    // Clean step: edge k is the first cycle below
    cyc(9'h001, 1'b1);
    repeat (4) cyc(9'h001, 1'b1);
    chk("step_early", 32'(sw_out), 32'h000);
    cyc(9'h001, 1'b1);
    chk("step_out",  32'(sw_out),  32'h001);
    chk("step_rise", 32'(rise),    32'h001);
    chk("step_chg",  32'(changed), 32'h1);
    cyc(9'h001, 1'b1);
    chk("step_rise_end", 32'(rise), 32'h000);

    // Bounce on bit 3, then hold high
    cyc(9'h009, 1'b1);
    cyc(9'h001, 1'b1);
    cyc(9'h009, 1'b1);
    cyc(9'h001, 1'b1);
    cyc(9'h009, 1'b1);
    repeat (4) cyc(9'h009, 1'b1);
    chk("bounce_early", 32'(sw_out[3]), 32'h0);
    cyc(9'h009, 1'b1);
    chk("bounce_out",  32'(sw_out[3]), 32'h1);
    chk("bounce_rise", 32'(rise[3]),   32'h1);
    repeat (4) cyc(9'h009, 1'b1);

    // Short glitch on bit 5 while it is high
    repeat (8) cyc(9'h029, 1'b1);
    chk("glitch_pre", 32'(sw_out[5]), 32'h1);
    f5 = 1'b0;
    repeat (3) begin
      cyc(9'h009, 1'b1);
      f5 = f5 | fall[5] | ~sw_out[5];
    end
    repeat (8) begin
      cyc(9'h029, 1'b1);
      f5 = f5 | fall[5] | ~sw_out[5];
    end
    chk("glitch_nofall", 32'(f5), 32'h0);

    // Simultaneous rise of bits 0, 7, 8
    repeat (10) cyc(9'h000, 1'b1);
    cyc(9'h181, 1'b1);
    repeat (4) cyc(9'h181, 1'b1);
    chk("simul_early", 32'(sw_out), 32'h000);
    cyc(9'h181, 1'b1);
    chk("simul_out",  32'(sw_out),  32'h181);
    chk("simul_rise", 32'(rise),    32'h181);
    chk("simul_chg",  32'(changed), 32'h1);
    cyc(9'h181, 1'b1);
    chk("simul_chg_end", 32'(changed), 32'h0);

    // Reset asserted mid-count on bit 2
    cyc(9'h185, 1'b1);
    repeat (3) cyc(9'h185, 1'b1);
    cyc(9'h185, 1'b0);
    chk("rstmid_out", 32'(sw_out), 32'h000);
    repeat (5) cyc(9'h185, 1'b1);
    chk("rstmid_early", 32'(sw_out[2]), 32'h0);
    cyc(9'h185, 1'b1);
    chk("rstmid_out2",  32'(sw_out[2]), 32'h1);
    chk("rstmid_rise2", 32'(rise[2]),   32'h1);

    // Random toggling with occasional resets
    v = 9'h185;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0)
        v = v ^ W'($urandom & $urandom & $urandom);
      cyc(v, ($urandom_range(0, 299) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
